grey_to_rgb565: RTL and testbench
=================================

# grey_to_rgb565

Pipelined 8-bit greyscale to RGB565 pixel converter with selectable colour mapping: mono, heatmap, binary threshold or inverted mono. It sits downstream of the RGB565-to-grey stage and any grey-domain processing, on the path back to the RGB565 display/framebuffer. It carries start-of-frame and end-of-line markers alongside the pixels and supports valid/ready backpressure. The mapping mode is switched only on frame boundaries.

## Interface
Parameters:
- P_MODE_RESET, 2'd0: mapping mode used after reset until the first accepted start-of-frame beat.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_mode  in  2  requested mode: 0 mono, 1 heatmap, 2 threshold, 3 inverted mono; quasi-static
- i_thresh  in  8  threshold for mode 2; quasi-static
- i_grey  in  8  input grey pixel
- i_sof  in  1  first pixel of frame, qualified by i_valid
- i_eol  in  1  last pixel of line, qualified by i_valid
- i_valid  in  1  input beat valid
- o_ready  out  1  input side may accept a beat
- o_rgb565  out  16  output pixel {R[4:0],G[5:0],B[4:0]}
- o_sof  out  1  sof carried with the pixel
- o_eol  out  1  eol carried with the pixel
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the beat

## Operation
- Input beat accepted when i_valid && o_ready. Output beat transferred when o_valid && i_ready.
- Effective mode and threshold of a beat:
  - beat with i_sof=1: i_mode / i_thresh at acceptance; these are also latched into the active registers.
  - any other beat: the active registers.
  - mode/threshold changes mid-frame have no effect until the next sof beat.
- Mode 0, mono: R8=G8=B8=g.
- Mode 3, inverted mono: R8=G8=B8=~g.
- Mode 2, threshold: all channels 8'hFF if g >= thresh, else 8'h00. Compare is unsigned.
- Mode 1, heatmap: seg=g[7:6], off4={g[5:0],2'b00}.
  - seg0: R=0, G=off4, B=255
  - seg1: R=0, G=255, B=255-off4
  - seg2: R=off4, G=255, B=0
  - seg3: R=255, G=255-off4, B=0
  - All 8-bit unsigned arithmetic; no overflow is possible (off4 ≤ 252).
- Packing: truncation only, no rounding. o_rgb565={R8[7:3],G8[7:2],B8[7:3]}.
- sof/eol travel in lockstep with their pixel and are otherwise unmodified.

## Timing
- Three register stages:
  - S1 captures grey, sof, eol, effective mode and threshold.
  - S2 holds R8/G8/B8.
  - S3 holds the packed output.
- Latency is 3 cycles from input acceptance to o_valid, with no stall.
- Global-stall pipeline: advance = i_ready || !o_valid. When advance=1, every stage loads from its predecessor, with valid bits included.
- o_ready = advance (combinational from i_ready and o_valid).
  - Bubbles inside the pipe are not compressed while the output is stalled.
  - Throughput is 1 pixel/cycle when i_ready=1.
- While stalled (advance=0), all stage registers, including o_rgb565/o_sof/o_eol, hold. No beat is lost or duplicated.
- Reset state:
  - Stage valids = 0 and all data registers = 0.
  - o_valid=0, o_rgb565=16'h0000, o_sof=0, o_eol=0.
  - Active mode = P_MODE_RESET, active threshold = 8'h80.
  - o_ready=1 during and after reset.
- Reset asserted mid-frame discards all in-flight beats immediately, because reset is asynchronous. After release, output resumes only with newly accepted beats.
- Simultaneous sof acceptance and mode change: the sof beat uses the new mode. The beats still in S1–S3 keep the mode they were tagged with.

## Structure
- Shared package grey_pkg:
  - mode encodings GREY_MODE_MONO/HEAT/THRESH/INV
  - RGB565 field widths
  - reset threshold constant 8'h80
- Sub-module grey_colormap: combinational g, mode, thresh -> R8, G8, B8, instantiated between S1 and S2.
- Packing and the handshake logic live in the top module.

## Test plan
- Mono, i_grey=8'hA5 -> o_rgb565=16'hA534 three cycles later. Mode 3 with 8'h00 -> 16'hFFFF.
- Heatmap:
  - 8'h00 -> 16'h001F
  - 8'h40 -> 16'h07FF
  - 8'h80 -> 16'h07E0
  - 8'hFF -> 16'hF800
- Threshold 8'h80 (set on the sof beat): 8'h7F -> 16'h0000; 8'h80 -> 16'hFFFF.
- Streaming 0..63 with i_ready low for cycles 5–9 -> all 64 outputs in order, no duplicates or gaps; o_ready low exactly while o_valid && !i_ready.
- Sequence:
  - mode 0 on sof, switch i_mode to 1 mid-frame -> remaining pixels stay mono.
  - next sof beat and after -> heatmap.
  - o_sof/o_eol aligned with their pixels.
- Assert i_rst_n low with 3 beats in flight -> o_valid=0 and o_rgb565=0 immediately; no stale beat emitted after release.

Source files
------------

// File: rtl/grey_pkg.sv
// grey_pkg: shared mode encodings, RGB565 field widths and reset constants for the grey-to-RGB565 path
package grey_pkg;
   typedef enum logic [1:0] {
      GREY_MODE_MONO   = 2'd0,
      GREY_MODE_HEAT   = 2'd1,
      GREY_MODE_THRESH = 2'd2,
      GREY_MODE_INV    = 2'd3
   } grey_mode_e;
   localparam int R_W = 5;
   localparam int G_W = 6;
   localparam int B_W = 5;
   localparam logic [7:0] GREY_THRESH_RST = 8'h80;
   function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {r[7 -: R_W], g[7 -: G_W], b[7 -: B_W]};
   endfunction
endpackage

// File: rtl/grey_colormap.sv
// grey_colormap: combinational mapping of one grey pixel to 8-bit R/G/B under the selected mode
module grey_colormap
   import grey_pkg::*;
(
   input  logic [7:0] grey,
   input  grey_mode_e mode,
   input  logic [7:0] thresh,
   output logic [7:0] r8,
   output logic [7:0] g8,
   output logic [7:0] b8
);
   logic [7:0] off4, bin, heat_r, heat_g, heat_b;
   assign off4 = {grey[5:0], 2'b00};
   assign bin = (grey >= thresh) ? 8'hFF : 8'h00;
   // four-segment ramp: blue -> cyan -> green -> yellow-ish -> red
   assign heat_r = grey[7] ? (grey[6] ? 8'hFF : off4) : 8'h00;
   assign heat_g = (grey[7:6] == 2'd0) ? off4 : (grey[7:6] == 2'd3) ? 8'hFF - off4 : 8'hFF;
   assign heat_b = grey[7] ? 8'h00 : grey[6] ? 8'hFF - off4 : 8'hFF;
   always_comb begin
      r8 = (mode == GREY_MODE_HEAT) ? heat_r : (mode == GREY_MODE_THRESH) ? bin : (mode == GREY_MODE_INV) ? ~grey : grey;
      g8 = (mode == GREY_MODE_HEAT) ? heat_g : (mode == GREY_MODE_THRESH) ? bin : (mode == GREY_MODE_INV) ? ~grey : grey;
      b8 = (mode == GREY_MODE_HEAT) ? heat_b : (mode == GREY_MODE_THRESH) ? bin : (mode == GREY_MODE_INV) ? ~grey : grey;
   end
endmodule

// File: rtl/grey_to_rgb565.sv
// grey_to_rgb565: three-stage global-stall pipeline converting grey pixels to RGB565 with frame-latched mode
module grey_to_rgb565
   import grey_pkg::*;
#(
   parameter logic [1:0] P_MODE_RESET = 2'd0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_mode,
   input  logic [7:0]  i_thresh,
   input  logic [7:0]  i_grey,
   input  logic        i_sof,
   input  logic        i_eol,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [15:0] o_rgb565,
   output logic        o_sof,
   output logic        o_eol,
   output logic        o_valid,
   input  logic        i_ready
);
   logic       adv, sof_in;
   grey_mode_e mode_act, mode_in, s1_mode;
   logic [7:0] thr_act, thr_in, s1_grey, s1_thr, r8, g8, b8, s2_r, s2_g, s2_b;
   logic       s1_v, s1_sof, s1_eol, s2_v, s2_sof, s2_eol;
   assign adv = i_ready || !o_valid;
   assign o_ready = adv;
   assign sof_in = i_valid && i_sof;
   // a sof beat uses the requested settings directly, the rest of the frame uses the latched copy
   assign mode_in = sof_in ? grey_mode_e'(i_mode) : mode_act;
   assign thr_in = sof_in ? i_thresh : thr_act;
   grey_colormap u_map (
      .grey   (s1_grey),
      .mode   (s1_mode),
      .thresh (s1_thr),
      .r8     (r8),
      .g8     (g8),
      .b8     (b8)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_act <= grey_mode_e'(P_MODE_RESET);
         thr_act  <= GREY_THRESH_RST;
         s1_v     <= 1'b0;
         s1_sof   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_grey  <= 8'h00;
         s1_mode  <= GREY_MODE_MONO;
         s1_thr   <= 8'h00;
         s2_v     <= 1'b0;
         s2_sof   <= 1'b0;
         s2_eol   <= 1'b0;
         s2_r     <= 8'h00;
         s2_g     <= 8'h00;
         s2_b     <= 8'h00;
         o_valid  <= 1'b0;
         o_sof    <= 1'b0;
         o_eol    <= 1'b0;
         o_rgb565 <= 16'h0000;
      end else if (adv) begin
         if (sof_in) begin
            mode_act <= grey_mode_e'(i_mode);
            thr_act  <= i_thresh;
         end
         s1_v     <= i_valid;
         s1_sof   <= i_sof;
         s1_eol   <= i_eol;
         s1_grey  <= i_grey;
         s1_mode  <= mode_in;
         s1_thr   <= thr_in;
         s2_v     <= s1_v;
         s2_sof   <= s1_sof;
         s2_eol   <= s1_eol;
         s2_r     <= r8;
         s2_g     <= g8;
         s2_b     <= b8;
         o_valid  <= s2_v;
         o_sof    <= s2_sof;
         o_eol    <= s2_eol;
         o_rgb565 <= pack565(s2_r, s2_g, s2_b);
      end
   end
endmodule

// File: tb/tb_grey_to_rgb565.sv
// tb_grey_to_rgb565: random and directed stimulus checked against an arithmetic pixel model and a beat queue
module tb_grey_to_rgb565;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  i_mode = 2'd0;
   logic [7:0]  i_thresh = 8'h00, i_grey = 8'h00;
   logic        i_sof = 1'b0, i_eol = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
   logic        o_ready, o_sof, o_eol, o_valid;
   logic [15:0] o_rgb565;
   int          errors = 0, checks = 0, nout = 0;
   logic [17:0] q[$];
   logic [1:0]  m_mode;
   logic [7:0]  m_thr;
   bit          have_prev = 0, prev_stall = 0;
   logic [17:0] prev_out;
   always #5 clk = ~clk;
   grey_to_rgb565 dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_mode   (i_mode),
      .i_thresh (i_thresh),
      .i_grey   (i_grey),
      .i_sof    (i_sof),
      .i_eol    (i_eol),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_rgb565 (o_rgb565),
      .o_sof    (o_sof),
      .o_eol    (o_eol),
      .o_valid  (o_valid),
      .i_ready  (i_ready)
   );
   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] model(input logic [7:0] g, input logic [1:0] m, input logic [7:0] t);
      int r, gg, b, seg, off;
      logic [7:0] r8, g8, b8;
      seg = int'(g) / 64;
      off = (int'(g) % 64) * 4;
      r = g; gg = g; b = g;
      if (m == 2'd3) begin r = 255 - g; gg = 255 - g; b = 255 - g; end
      if (m == 2'd2) begin r = (g >= t) ? 255 : 0; gg = r; b = r; end
      if (m == 2'd1) begin
         r  = (seg == 0 || seg == 1) ? 0 : (seg == 2) ? off : 255;
         gg = (seg == 0) ? off : (seg == 3) ? 255 - off : 255;
         b  = (seg == 0) ? 255 : (seg == 1) ? 255 - off : 0;
      end
      r8 = r[7:0]; g8 = gg[7:0]; b8 = b[7:0];
      return {r8[7:3], g8[7:2], b8[7:3]};
   endfunction
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_mode = 2'd0;
         m_thr = 8'h80;
         have_prev = 0;
      end else begin
         check(o_ready === (i_ready || !o_valid), "ready", o_ready, i_ready || !o_valid);
         if (have_prev && prev_stall)
            check(o_valid && {o_rgb565, o_sof, o_eol} === prev_out, "hold", {o_rgb565, o_sof, o_eol}, prev_out);
         if (o_valid && i_ready) begin
            if (q.size() == 0) check(0, "stale", o_rgb565, 0);
            else begin
               logic [17:0] e;
               e = q.pop_front();
               check({o_rgb565, o_sof, o_eol} === e, "pixel", {o_rgb565, o_sof, o_eol}, e);
            end
            nout++;
         end
         if (i_valid && o_ready) begin
            if (i_sof) begin m_mode = i_mode; m_thr = i_thresh; end
            q.push_back({model(i_grey, m_mode, m_thr), i_sof, i_eol});
         end
         have_prev = 1;
         prev_stall = o_valid && !i_ready;
         prev_out = {o_rgb565, o_sof, o_eol};
      end
   end
   task automatic lit(input logic [7:0] g, input logic [1:0] im, input logic [1:0] em, input logic [7:0] t,
                      input bit sof, input logic [15:0] exp, input string name);
      int n;
      i_ready = 1; i_valid = 1; i_sof = sof; i_eol = 1; i_grey = g; i_mode = im; i_thresh = t;
      n = 0;
      do begin
         @(posedge clk); #1;
         i_valid = 0;
         n++;
      end while (!o_valid && n < 10);
      check(n == 3, {name, "_lat"}, n, 3);
      check(o_rgb565 === exp, name, o_rgb565, exp);
      check(model(g, em, t) === exp, {name, "_model"}, model(g, em, t), exp);
   endtask
   task automatic idle(input int n);
      i_valid = 0; i_ready = 1;
      repeat (n) begin @(posedge clk); #1; end
   endtask
   initial begin
      int b, t, n0, seen;
      bit acc;
      #1;
      check(o_ready === 1'b1, "rst_ready", o_ready, 1);
      check(o_valid === 1'b0, "rst_valid", o_valid, 0);
      check({o_rgb565, o_sof, o_eol} === 18'h0, "rst_data", {o_rgb565, o_sof, o_eol}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      check(o_valid === 1'b0 && o_rgb565 === 16'h0, "post_rst", o_rgb565, 0);
      lit(8'hA5, 2'd1, 2'd0, 8'h80, 0, 16'hA534, "reset_mode_mono");
      lit(8'hA5, 2'd0, 2'd0, 8'h00, 1, 16'hA534, "mono_a5");
      lit(8'h00, 2'd3, 2'd3, 8'h00, 1, 16'hFFFF, "inv_00");
      lit(8'h00, 2'd1, 2'd1, 8'h00, 1, 16'h001F, "heat_00");
      lit(8'h40, 2'd1, 2'd1, 8'h00, 1, 16'h07FF, "heat_40");
      lit(8'h80, 2'd1, 2'd1, 8'h00, 1, 16'h07E0, "heat_80");
      lit(8'hFF, 2'd1, 2'd1, 8'h00, 1, 16'hF800, "heat_ff");
      lit(8'h7F, 2'd2, 2'd2, 8'h80, 1, 16'h0000, "thr_7f");
      lit(8'h80, 2'd2, 2'd2, 8'h80, 1, 16'hFFFF, "thr_80");
      idle(5);
      b = 0; t = 0; n0 = nout;
      i_mode = 2'd0;
      while (b < 64 && t < 200) begin
         i_valid = 1; i_grey = 8'(b); i_sof = (b == 0); i_eol = (b % 8 == 7);
         i_ready = !(t >= 5 && t <= 9);
         @(negedge clk);
         acc = o_ready;
         @(posedge clk); #1;
         if (acc) b++;
         t++;
      end
      idle(8);
      check(nout - n0 == 64, "stream_count", nout - n0, 64);
      check(q.size() == 0, "stream_drain", q.size(), 0);
      for (int k = 0; k < 12; k++) begin
         i_valid = 1; i_ready = 1; i_grey = 8'($urandom); i_sof = (k == 0 || k == 8); i_eol = (k == 7);
         i_mode = (k < 3) ? 2'd0 : 2'd1;
         @(posedge clk); #1;
      end
      idle(6);
      for (int k = 0; k < 3; k++) begin
         i_valid = 1; i_ready = 1; i_grey = 8'(8'h10 + k); i_sof = 0; i_eol = 0;
         @(posedge clk); #1;
      end
      i_valid = 0;
      check(o_valid === 1'b1, "inflight", o_valid, 1);
      rst_n = 0;
      #1;
      check(o_valid === 1'b0, "async_rst_valid", o_valid, 0);
      check(o_rgb565 === 16'h0, "async_rst_data", o_rgb565, 0);
      check(o_ready === 1'b1, "async_rst_ready", o_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (o_valid) seen++; end
      check(seen == 0, "no_stale", seen, 0);
      for (int k = 0; k < 3000; k++) begin
         i_valid = ($urandom_range(9) < 7);
         i_sof = ($urandom_range(9) == 0);
         i_eol = ($urandom_range(6) == 0);
         i_grey = 8'($urandom);
         if ($urandom_range(15) == 0) i_mode = 2'($urandom);
         if ($urandom_range(15) == 0) i_thresh = 8'($urandom);
         i_ready = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      idle(10);
      check(q.size() == 0, "final_drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
